pwm_sched: RTL

Synthesizable controller that sequences a duty-cycle waveform generator from per-period low/high cycle counts, replacing delay-based on/off timing with clocked counters. Configurations arrive over a valid/ready handshake and are double-buffered: an active set runs while one shadow set waits. A new set takes effect only at a period boundary, so no glitched or truncated periods appear. Sits between a control/register block and any consumer of a gated clock-enable or PWM line.

---
 rtl/pwm_sched.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pwm_sched.sv
// Double-buffered PWM period sequencer: runs low/high phase counts per period,
// swapping in a shadow configuration or stopping only at period boundaries.
module pwm_sched #(
   parameter int CW = 8,
   parameter int NW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   input  logic [CW-1:0] cfg_low,
   input  logic [CW-1:0] cfg_high,
   input  logic [NW-1:0] cfg_cycles,
   input  logic          stop,
   output logic          pwm_out,
   output logic          busy,
   output logic          period_tick,
   output logic          done
);
   typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

   state_t        st, st_n;
   logic [CW-1:0] cnt, cnt_n, a_low, a_low_n, a_high, a_high_n;
   logic [CW-1:0] s_low, s_high, r_low, r_high, ld_low, ld_high;
   logic [NW-1:0] a_cyc, a_cyc_n, per, per_n, s_cyc, ld_cyc;
   logic          s_full, s_full_n, stop_p, stop_p_n, done_n, tick_n;
   logic          xfer, ld, restart, last_per;

   assign cfg_ready = (st == IDLE) || !s_full;
   assign xfer      = cfg_valid && cfg_ready;
   assign last_per  = (a_cyc != '0) && (per == a_cyc - NW'(1));

   always_comb begin
      st_n     = st;
      cnt_n    = cnt;
      a_low_n  = a_low;
      a_high_n = a_high;
      a_cyc_n  = a_cyc;
      per_n    = per;
      s_full_n = s_full;
      stop_p_n = stop_p;
      done_n   = 1'b0;
      ld       = 1'b0;
      restart  = 1'b0;
      // A held shadow wins; otherwise a same-cycle transfer feeds the boundary directly
      ld_low   = s_full ? s_low  : cfg_low;
      ld_high  = s_full ? s_high : cfg_high;
      ld_cyc   = s_full ? s_cyc  : cfg_cycles;
      case (st)
         IDLE: ld = xfer;
         default: begin
            stop_p_n = stop_p | stop;
            if (!period_tick) begin
               if (st == LOW && cnt == CW'(1)) begin
                  st_n  = HIGH;
                  cnt_n = a_high;
               end else begin
                  cnt_n = cnt - CW'(1);
               end
               if (xfer) s_full_n = 1'b1;
            end else begin
               stop_p_n = 1'b0;
               if (stop_p || stop) begin
                  st_n     = IDLE;
                  s_full_n = 1'b0;
                  done_n   = 1'b1;
               end else if ((s_full || xfer) && (a_cyc == '0 || last_per)) begin
                  ld       = 1'b1;
                  s_full_n = 1'b0;
               end else if (last_per) begin
                  st_n   = IDLE;
                  done_n = 1'b1;
               end else begin
                  restart = 1'b1;
                  if (a_cyc != '0) per_n = per + NW'(1);
                  if (xfer) s_full_n = 1'b1;
               end
            end
         end
      endcase
      if (ld) begin
         a_low_n  = ld_low;
         a_high_n = ld_high;
         a_cyc_n  = ld_cyc;
         per_n    = '0;
         stop_p_n = 1'b0;
         restart  = 1'b1;
      end
      r_low  = a_low_n;
      r_high = a_high_n;
      if (restart) begin
         if (r_low == '0 && r_high == '0) begin
            st_n  = LOW;
            cnt_n = CW'(1);
         end else if (r_low != '0) begin
            st_n  = LOW;
            cnt_n = r_low;
         end else begin
            st_n  = HIGH;
            cnt_n = r_high;
         end
      end
      // Look ahead so the registered tick lands in the final cycle of the period
      tick_n = (cnt_n == CW'(1)) && (st_n == HIGH || (st_n == LOW && a_high_n == '0));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st          <= IDLE;
         cnt         <= '0;
         a_low       <= '0;
         a_high      <= '0;
         a_cyc       <= '0;
         per         <= '0;
         s_full      <= 1'b0;
         stop_p      <= 1'b0;
         s_low       <= '0;
         s_high      <= '0;
         s_cyc       <= '0;
         pwm_out     <= 1'b0;
         busy        <= 1'b0;
         period_tick <= 1'b0;
         done        <= 1'b0;
      end else begin
         st          <= st_n;
         cnt         <= cnt_n;
         a_low       <= a_low_n;
         a_high      <= a_high_n;
         a_cyc       <= a_cyc_n;
         per         <= per_n;
         s_full      <= s_full_n;
         stop_p      <= stop_p_n;
         if (xfer && st != IDLE) begin
            s_low  <= cfg_low;
            s_high <= cfg_high;
            s_cyc  <= cfg_cycles;
         end
         pwm_out     <= (st_n == HIGH);
         busy        <= (st_n != IDLE);
         period_tick <= tick_n;
         done        <= done_n;
      end
   end
endmodule
